// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// One outstanding CPU request at a time; misses refill a whole 16-byte line,
// stores always go to memory and only touch the cache on a hit.
module dcache_ctrl #(
  parameter int LINES = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  cpu_addr,
  input  logic         cpu_re,
  input  logic [3:0]   cpu_we,
  input  logic [31:0]  cpu_din,
  output logic [31:0]  cpu_dout,
  output logic         stall,
  output logic         mem_req_valid,
  input  logic         mem_req_ready,
  output logic         mem_req_rw,
  output logic [27:0]  mem_req_addr,
  output logic [127:0] mem_req_data,
  output logic [15:0]  mem_req_mask,
  input  logic         mem_resp_valid,
  input  logic [127:0] mem_resp_data
);

  localparam int IDX_W = $clog2(LINES);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    MISS_WAIT,
    REFILL_DONE,
    WRITE_REQ
  } state_t;

  state_t state, state_d;

  // Captured request; the byte offset is irrelevant for word-wide access.
  logic [31:2]         req_addr;
  logic [31:0]         req_din;
  logic [3:0]          req_we;
  logic                req_store;

  logic [LINES-1:0]    valid_q;
  logic [31:IDX_W+4]   tag_mem  [LINES];
  logic [127:0]        data_mem [LINES];
  logic [31:0]         dout_q;

  logic [IDX_W-1:0]    req_index;
  logic [1:0]          req_word;
  logic                hit;
  logic [31:0]         hit_word;
  logic [127:0]        merged_line;
  logic                cpu_valid;
  logic                take;
  logic                unused_addr_bits;

  assign req_index        = req_addr[IDX_W+3:4];
  assign req_word         = req_addr[3:2];
  assign hit              = valid_q[req_index] && (tag_mem[req_index] == req_addr[31:IDX_W+4]);
  assign hit_word         = data_mem[req_index][32*int'(req_word) +: 32];
  assign cpu_valid        = cpu_re || (cpu_we != 4'b0000);
  assign take             = !stall && cpu_valid;
  assign unused_addr_bits = ^cpu_addr[1:0];

  // Memory request fields come straight from the captured request, so they
  // cannot change while a request is pending (capture is blocked by stall).
  assign mem_req_rw   = req_store;
  assign mem_req_addr = req_addr[31:4];
  assign mem_req_data = {4{req_din}};

  // Place the store byte enables on the lanes of the addressed word.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    mem_req_mask = 16'h0000;
    case (req_word)
      2'd0: mem_req_mask = {12'h000, req_we};
      2'd1: mem_req_mask = {8'h00, req_we, 4'h0};
      2'd2: mem_req_mask = {4'h0, req_we, 8'h00};
      2'd3: mem_req_mask = {req_we, 12'h000};
      default: mem_req_mask = 16'h0000;
    endcase
  end

  // Cached line with the enabled store bytes merged into the addressed word.
  always_comb begin
    merged_line = data_mem[req_index];
    for (int b = 0; b < 4; b++) begin
      if (req_we[b]) merged_line[32*int'(req_word) + 8*b +: 8] = req_din[8*b +: 8];
    end
  end

  // Next-state logic plus stall, request-valid and load-data outputs.
  always_comb begin
    state_d       = state;
    stall         = 1'b0;
    mem_req_valid = 1'b0;
    cpu_dout      = dout_q;
    case (state)
      IDLE: begin
        if (cpu_valid) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (req_store) begin
          stall   = 1'b1;
          state_d = WRITE_REQ;
        end else if (hit) begin
          cpu_dout = hit_word;
          state_d  = cpu_valid ? LOOKUP : IDLE;
        end else begin
          stall   = 1'b1;
          state_d = MISS_REQ;
        end
      end
      MISS_REQ: begin
        stall         = 1'b1;
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = MISS_WAIT;
      end
      MISS_WAIT: begin
        stall = 1'b1;
        if (mem_resp_valid) state_d = REFILL_DONE;
      end
      REFILL_DONE: begin
        cpu_dout = hit_word;
        state_d  = cpu_valid ? LOOKUP : IDLE;
      end
      WRITE_REQ: begin
        stall         = 1'b1;
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, request capture, valid bits and held load data.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state     <= IDLE;
      req_addr  <= '0;
      req_din   <= '0;
      req_we    <= '0;
      req_store <= 1'b0;
      valid_q   <= '0;
      dout_q    <= '0;
    end else begin
      state  <= state_d;
      dout_q <= cpu_dout;
      if (take) begin
        req_addr  <= cpu_addr[31:2];
        req_din   <= cpu_din;
        req_we    <= cpu_we;
        req_store <= (cpu_we != 4'b0000);
      end
      if (state == MISS_WAIT && mem_resp_valid) valid_q[req_index] <= 1'b1;
    end
  end

  // Tag and data arrays: refill on response, byte merge on store hit.
  always_ff @(posedge clk) begin
    // NOTE: the arrays are deliberately not reset; cleared valid bits keep stale contents from hitting.
    if (!reset) begin
      if (state == MISS_WAIT && mem_resp_valid) begin
        data_mem[req_index] <= mem_resp_data;
        tag_mem[req_index]  <= req_addr[31:IDX_W+4];
      end else if (state == LOOKUP && req_store && hit) begin
        data_mem[req_index] <= merged_line;
      end
    end
  end

endmodule
